// File: rtl/elevator_floor_ctrl.sv
// elevator_floor_ctrl
//   Single-car elevator controller. Latches floor calls, moves the car one floor
//   per MOVE_CYCLES using a SCAN policy (keep heading while calls remain ahead,
//   reverse only when idle), holds the door open for DOOR_CYCLES and drives the
//   4-bit binary floor code read by the 7-segment decoder.
//
//   Optional feature macro: ELEV_ESTOP_EN
//     defined   -> adds the level input 'estop'. While it is high the state,
//                  floor, heading and both timers freeze, the movement outputs
//                  read 0, door_open keeps its value and calls are still
//                  latched. Reset overrides estop.
//     undefined -> no estop port and no freeze logic.
module elevator_floor_ctrl #(
    parameter int NUM_FLOORS  = 8,
    parameter int MOVE_CYCLES = 50,
    parameter int DOOR_CYCLES = 100
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef ELEV_ESTOP_EN
    input  logic                  estop,
`endif
    input  logic [NUM_FLOORS-1:0] req,
    output logic [3:0]            floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    // Counter widths; a one-cycle period still needs a 1-bit register.
    localparam int MOVE_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [3:0]        TOP_FLOOR = 4'(NUM_FLOORS - 1);

    // Controller states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVING = 2'd1;
    localparam logic [1:0] ST_DOOR   = 2'd2;

    // Heading encoding
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Architectural state
    logic [1:0]            r_state;
    logic                  r_dir;
    logic [3:0]            r_floor;
    logic [MOVE_W-1:0]     r_move_cnt;
    logic [DOOR_W-1:0]     r_door_cnt;
    logic [NUM_FLOORS-1:0] r_pending;

    // Registered status outputs
    logic                  r_moving_up;
    logic                  r_moving_down;
    logic                  r_door_open;

    // Derived views of the current position and call set
    logic                  w_freeze;
    logic [3:0]            w_floor_step;
    logic                  w_at_limit;
    logic                  w_call_above;
    logic                  w_call_below;
    logic                  w_call_ahead;
    logic                  w_call_behind;
    logic                  w_req_here;
    logic                  w_pend_at_step;
    logic [NUM_FLOORS-1:0] w_here_onehot;
    logic [NUM_FLOORS-1:0] w_step_onehot;
    logic                  w_block_here;

    // Next-state values
    logic [1:0]            w_state_nxt;
    logic                  w_dir_nxt;
    logic [3:0]            w_floor_nxt;
    logic [MOVE_W-1:0]     w_move_cnt_nxt;
    logic [DOOR_W-1:0]     w_door_cnt_nxt;
    logic [NUM_FLOORS-1:0] w_clr_mask;
    logic [NUM_FLOORS-1:0] w_latch_mask;
    logic [NUM_FLOORS-1:0] w_pending_nxt;

`ifdef ELEV_ESTOP_EN
    assign w_freeze = estop;
`else
    assign w_freeze = 1'b0;
`endif

    // Floor the car reaches at the end of the current move, and whether the
    // car already sits at the end of the shaft in its heading.
    assign w_floor_step = (r_dir == DIR_UP) ? (r_floor + 4'd1) : (r_floor - 4'd1);
    assign w_at_limit   = (r_dir == DIR_UP) ? (r_floor == TOP_FLOOR) : (r_floor == 4'd0);

    // Scan the latched calls relative to the car and pick out the bits at the
    // current floor and at the floor the car is heading to.
    always_comb begin
        w_call_above   = 1'b0;
        w_call_below   = 1'b0;
        w_req_here     = 1'b0;
        w_pend_at_step = 1'b0;
        w_here_onehot  = '0;
        w_step_onehot  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(r_floor)) begin
                w_call_above = w_call_above | r_pending[i];
            end
            if (i < int'(r_floor)) begin
                w_call_below = w_call_below | r_pending[i];
            end
            if (i == int'(r_floor)) begin
                w_req_here       = req[i];
                w_here_onehot[i] = 1'b1;
            end
            if (i == int'(w_floor_step)) begin
                w_pend_at_step   = r_pending[i];
                w_step_onehot[i] = 1'b1;
            end
        end
    end

    assign w_call_ahead  = (r_dir == DIR_UP) ? w_call_above : w_call_below;
    assign w_call_behind = (r_dir == DIR_UP) ? w_call_below : w_call_above;

    // SCAN state machine: decide the next state, heading, floor and timers.
    always_comb begin
        w_state_nxt    = r_state;
        w_dir_nxt      = r_dir;
        w_floor_nxt    = r_floor;
        w_move_cnt_nxt = r_move_cnt;
        w_door_cnt_nxt = r_door_cnt;
        w_clr_mask     = '0;
        if (!w_freeze) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_here) begin
                        // Call at the floor the car is parked on: just open.
                        w_state_nxt    = ST_DOOR;
                        w_door_cnt_nxt = '0;
                    end else if (w_call_ahead) begin
                        w_state_nxt    = ST_MOVING;
                        w_move_cnt_nxt = '0;
                    end else if (w_call_behind) begin
                        // Nothing left ahead: the only place the heading flips.
                        w_dir_nxt      = ~r_dir;
                        w_state_nxt    = ST_MOVING;
                        w_move_cnt_nxt = '0;
                    end
                end
                ST_MOVING: begin
                    if (r_move_cnt == MOVE_LAST) begin
                        w_move_cnt_nxt = '0;
                        if (w_at_limit) begin
                            // Unreachable while a call is always ahead; parks the
                            // car instead of stepping off the shaft.
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_floor_nxt = w_floor_step;
                            if (w_pend_at_step) begin
                                w_clr_mask     = w_step_onehot;
                                w_state_nxt    = ST_DOOR;
                                w_door_cnt_nxt = '0;
                            end
                        end
                    end else begin
                        w_move_cnt_nxt = r_move_cnt + MOVE_W'(1);
                    end
                end
                ST_DOOR: begin
                    if (w_req_here) begin
                        // Door hold: a fresh call here restarts the dwell.
                        w_door_cnt_nxt = '0;
                    end else if (r_door_cnt == DOOR_LAST) begin
                        w_door_cnt_nxt = '0;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_door_cnt_nxt = r_door_cnt + DOOR_W'(1);
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_move_cnt_nxt = '0;
                    w_door_cnt_nxt = '0;
                end
            endcase
        end
    end

    // A call for the floor the car stands at with the door usable is answered
    // directly and never enters the pending set; a serviced bit always clears.
    assign w_block_here  = (r_state == ST_IDLE) || (r_state == ST_DOOR);
    assign w_latch_mask  = w_block_here ? ~w_here_onehot : {NUM_FLOORS{1'b1}};
    assign w_pending_nxt = (r_pending | (req & w_latch_mask)) & ~w_clr_mask;

    // State, call and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_dir         <= DIR_UP;
            r_floor       <= 4'd0;
            r_move_cnt    <= '0;
            r_door_cnt    <= '0;
            r_pending     <= '0;
            r_moving_up   <= 1'b0;
            r_moving_down <= 1'b0;
            r_door_open   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dir         <= w_dir_nxt;
            r_floor       <= w_floor_nxt;
            r_move_cnt    <= w_move_cnt_nxt;
            r_door_cnt    <= w_door_cnt_nxt;
            r_pending     <= w_pending_nxt;
            r_moving_up   <= (w_state_nxt == ST_MOVING) && (w_dir_nxt == DIR_UP) && !w_freeze;
            r_moving_down <= (w_state_nxt == ST_MOVING) && (w_dir_nxt == DIR_DOWN) && !w_freeze;
            r_door_open   <= (w_state_nxt == ST_DOOR);
        end
    end

    assign floor       = r_floor;
    assign moving_up   = r_moving_up;
    assign moving_down = r_moving_down;
    assign door_open   = r_door_open;
    assign pending     = r_pending;

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// tb_elevator_floor_ctrl
//   Drives directed scenarios and random call traffic into elevator_floor_ctrl
//   (NUM_FLOORS=8, MOVE_CYCLES=4, DOOR_CYCLES=3) and compares every cycle
//   against a behavioural car model. Define ELEV_ESTOP_EN to include the
//   emergency-stop scenario.
module tb_elevator_floor_ctrl;

    localparam int NF   = 8;
    localparam int MOVE = 4;
    localparam int DOOR = 3;

    // Model phases (bench-local meaning only)
    localparam int PH_REST   = 0;
    localparam int PH_TRAVEL = 1;
    localparam int PH_DWELL  = 2;

    logic          clk;
    logic          reset;
    logic [NF-1:0] req;
    logic [3:0]    floor;
    logic          moving_up;
    logic          moving_down;
    logic          door_open;
    logic [NF-1:0] pending;
    bit            estop_v;

    int n_checks;
    int n_fail;

    // Behavioural model: position, heading (+1/-1), phase, cycles left in phase
    int m_pos;
    int m_head;
    int m_phase;
    int m_left;
    bit m_frozen;
    bit m_pend [NF];

    bit prev_door;
    int stops[$];

    elevator_floor_ctrl #(
        .NUM_FLOORS (NF),
        .MOVE_CYCLES(MOVE),
        .DOOR_CYCLES(DOOR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ELEV_ESTOP_EN
        .estop      (estop_v),
`endif
        .req        (req),
        .floor      (floor),
        .moving_up  (moving_up),
        .moving_down(moving_down),
        .door_open  (door_open),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic [NF-1:0] r, input bit rst, input bit stop);
        bit latch [NF];
        bit serve [NF];
        bit ahead;
        bit behind;
        if (rst) begin
            m_pos = 0; m_head = 1; m_phase = PH_REST; m_left = 0; m_frozen = 0;
            for (int i = 0; i < NF; i++) m_pend[i] = 0;
            return;
        end
        for (int i = 0; i < NF; i++) begin
            serve[i] = 0;
            latch[i] = r[i] && !(i == m_pos && (m_phase == PH_REST || m_phase == PH_DWELL));
        end
        if (!stop) begin
            case (m_phase)
                PH_REST: begin
                    ahead = 0; behind = 0;
                    for (int j = 0; j < NF; j++) begin
                        if (m_pend[j] && (j - m_pos) * m_head > 0) ahead = 1;
                        if (m_pend[j] && (j - m_pos) * m_head < 0) behind = 1;
                    end
                    if (r[m_pos]) begin
                        m_phase = PH_DWELL; m_left = DOOR;
                    end else if (ahead) begin
                        m_phase = PH_TRAVEL; m_left = MOVE;
                    end else if (behind) begin
                        m_head = -m_head; m_phase = PH_TRAVEL; m_left = MOVE;
                    end
                end
                PH_TRAVEL: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_pos += m_head;
                        if (m_pend[m_pos]) begin
                            serve[m_pos] = 1; m_phase = PH_DWELL; m_left = DOOR;
                        end else begin
                            m_left = MOVE;
                        end
                    end
                end
                default: begin
                    if (r[m_pos]) m_left = DOOR;
                    else begin
                        m_left--;
                        if (m_left == 0) m_phase = PH_REST;
                    end
                end
            endcase
        end
        for (int i = 0; i < NF; i++) m_pend[i] = (m_pend[i] | latch[i]) && !serve[i];
        m_frozen = stop;
    endtask

    task automatic compare_model();
        logic [NF-1:0] mp;
        int ones;
        for (int i = 0; i < NF; i++) mp[i] = m_pend[i];
        check_val("floor", 32'(floor), 32'(m_pos));
        check_val("pending", 32'(pending), 32'(mp));
        check_val("moving_up", 32'(moving_up), 32'(m_phase == PH_TRAVEL && m_head > 0 && !m_frozen));
        check_val("moving_down", 32'(moving_down), 32'(m_phase == PH_TRAVEL && m_head < 0 && !m_frozen));
        check_val("door_open", 32'(door_open), 32'(m_phase == PH_DWELL));
        check_val("floor_range", 32'(floor <= 4'd7), 32'd1);
        ones = int'(moving_up) + int'(moving_down) + int'(door_open);
        check_val("status_exclusive", 32'(ones <= 1), 32'd1);
    endtask

    // Drive one cycle of inputs, step the model, then compare after the edge.
    task automatic tick(input logic [NF-1:0] r, input bit rst);
        req   = r;
        reset = rst;
        model_step(r, rst, estop_v);
        @(negedge clk);
        compare_model();
        if (door_open && !prev_door) stops.push_back(int'(floor));
        prev_door = door_open;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while ((moving_up || moving_down || door_open || pending != '0) && n < max) begin
            tick('0, 0);
            n++;
        end
        check_val(tag, 32'(n < max), 32'd1);
    endtask

    task automatic wait_floor(input string tag, input int target, input int max);
        int n;
        n = 0;
        while (int'(floor) != target && n < max) begin
            tick('0, 0);
            n++;
        end
        check_val(tag, 32'(n < max), 32'd1);
    endtask

    initial begin
        int mu_cnt;
        int door_cnt;
        int max_floor;
        logic [NF-1:0] hold_seq [8];

        n_checks = 0; n_fail = 0;
        estop_v = 0; prev_door = 0;
        reset = 1'b1; req = '0;
        @(negedge clk);
        tick('0, 1);
        tick('0, 1);
        check_val("rst_floor", 32'(floor), 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_status", 32'({moving_up, moving_down, door_open}), 32'd0);

        // Single call from floor 0 to floor 3
        tick(8'h08, 0);
        check_val("t2_pending", 32'(pending), 32'h08);
        mu_cnt = 0; door_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            tick('0, 0);
            if (moving_up) mu_cnt++;
            if (door_open) door_cnt++;
        end
        check_val("t2_move_cycles", 32'(mu_cnt), 32'd12);
        check_val("t2_door_cycles", 32'(door_cnt), 32'd3);
        check_val("t2_final_floor", 32'(floor), 32'd3);
        check_val("t2_pending_clr", 32'(pending), 32'd0);

        // Intermediate stops while travelling from 1 to 6, then reversal
        tick(8'h02, 0);
        wait_idle("t3_reach1", 100);
        tick(8'h40, 0);
        wait_floor("t3_at2", 2, 100);
        tick('0, 0);
        stops.delete();
        tick(8'h14, 0);
        wait_idle("t3_done", 200);
        check_val("t3_nstops", 32'(stops.size()), 32'd3);
        if (stops.size() == 3) begin
            check_val("t3_stop0", 32'(stops[0]), 32'd4);
            check_val("t3_stop1", 32'(stops[1]), 32'd6);
            check_val("t3_stop2", 32'(stops[2]), 32'd2);
        end

        // Door opening at the parked floor and door hold
        hold_seq = '{8'h04, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        door_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick(hold_seq[k], 0);
            if (door_open) door_cnt++;
            check_val("t4_no_move", 32'({moving_up, moving_down}), 32'd0);
        end
        check_val("t4_door_cycles", 32'(door_cnt), 32'd6);
        check_val("t4_pending", 32'(pending), 32'd0);
        check_val("t4_floor", 32'(floor), 32'd2);

        // Shaft ends: up to 7, back to 0
        tick(8'h01, 0);
        wait_idle("t5_to0", 100);
        tick(8'h80, 0);
        max_floor = 0;
        for (int k = 0; k < 60; k++) begin
            tick('0, 0);
            if (int'(floor) > max_floor) max_floor = int'(floor);
        end
        check_val("t5_top", 32'(floor), 32'd7);
        check_val("t5_max", 32'(max_floor), 32'd7);
        tick(8'h01, 0);
        wait_idle("t5_back", 100);
        check_val("t5_bottom", 32'(floor), 32'd0);

        // Reset in the middle of a trip
        tick(8'h80, 0);
        wait_floor("t1_at5", 5, 100);
        tick('0, 0);
        tick('0, 1);
        check_val("t1_floor", 32'(floor), 32'd0);
        check_val("t1_pending", 32'(pending), 32'd0);
        check_val("t1_status", 32'({moving_up, moving_down, door_open}), 32'd0);

`ifdef ELEV_ESTOP_EN
        // Freeze two cycles into a floor move
        tick(8'h02, 0);
        tick('0, 0);
        tick('0, 0);
        tick('0, 0);
        estop_v = 1;
        for (int k = 0; k < 5; k++) begin
            tick('0, 0);
            check_val("t6_mu_frozen", 32'(moving_up), 32'd0);
            check_val("t6_floor_frozen", 32'(floor), 32'd0);
        end
        estop_v = 0;
        tick('0, 0);
        check_val("t6_floor_r1", 32'(floor), 32'd0);
        tick('0, 0);
        check_val("t6_floor_r2", 32'(floor), 32'd1);
        wait_idle("t6_done", 100);
`endif

        // Random call traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            logic [NF-1:0] r;
            bit rst_r;
            r = ($urandom_range(0, 7) == 0) ? NF'($urandom) : '0;
            rst_r = ($urandom_range(0, 499) == 0);
`ifdef ELEV_ESTOP_EN
            if ($urandom_range(0, 39) == 0) estop_v = ~estop_v;
`endif
            tick(r, rst_r);
        end
        estop_v = 0;
        wait_idle("rand_drain", 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
